// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad key map and one-hot decode helpers
package keypad_pkg;

  // Nibble i holds the hex code of key index row*4+col.
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  typedef struct packed {
    logic       onehot;
    logic [3:0] index;
  } onehot_t;

  function automatic onehot_t onehot_index(input logic [15:0] vec);
    onehot_t    r;
    logic [4:0] cnt;
    r   = '0;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) begin
        cnt     = cnt + 5'd1;
        r.index = 4'(i);
      end
    end
    r.onehot = (cnt == 5'd1);
    return r;
  endfunction

  // Snapshot bit positions are col*4+row; the key map is indexed row*4+col.
  function automatic logic [3:0] key_code(input logic [3:0] bit_pos);
    logic [3:0] idx;
    idx = {bit_pos[1:0], bit_pos[3:2]};
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad scanner control, matrix and key event signals
interface keypad_scanner_if;
  logic        in_en;
  logic        in_clear;
  logic [3:0]  in_rows;
  logic [3:0]  out_cols;
  logic        out_key_valid;
  logic [3:0]  out_key_code;
  logic        out_key_pressed;
  logic [31:0] out_value;

  modport master (
    output in_en, in_clear, in_rows,
    input  out_cols, out_key_valid, out_key_code, out_key_pressed, out_value
  );

  modport slave (
    input  in_en, in_clear, in_rows,
    output out_cols, out_key_valid, out_key_code, out_key_pressed, out_value
  );
endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - commits a full-scan snapshot after consecutive identical scans
module keypad_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        scan_done_i,
  input  logic [15:0] snap_i,
  output logic [15:0] stable_o,
  output logic        commit_o
);
  localparam int MW = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS - 1);

  logic [15:0]   prev_q;
  logic [15:0]   stable_q;
  logic [MW-1:0] match_q, match_d;

  always_comb begin
    match_d = match_q;
    if (scan_done_i) begin
      if (snap_i != prev_q)
        match_d = '0;
      else if (match_q != MATCH_MAX)
        match_d = match_q + 1'b1;
    end
  end

  // Re-committing while saturated rewrites the same value, so it is harmless.
  assign commit_o = scan_done_i && (match_d == MATCH_MAX);
  assign stable_o = stable_q;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      prev_q   <= '0;
      stable_q <= '0;
      match_q  <= '0;
    end else begin
      match_q <= match_d;
      if (scan_done_i) prev_q   <= snap_i;
      if (commit_o)    stable_q <= snap_i;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with debounced press events
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SYSTEM_CLOCK_MHz = 100,
  parameter int SCAN_RATE_HZ     = 1000,
  parameter int DEBOUNCE_SCANS   = 4
) (
  input  logic           in_clk,
  input  logic           in_rst_n,
  keypad_scanner_if.slave kp
);
  localparam int DWELL = SYSTEM_CLOCK_MHz * 1000000 / SCAN_RATE_HZ;
  localparam int DIV_W = $clog2(DWELL);

  logic [3:0]       rows_s1_q, rows_s2_q, pressed;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       cols_q, cols_d;
  logic [15:0]      snap_q, snap_d;
  logic             tick, scan_done;
  logic [15:0]      stable;
  logic             commit;
  onehot_t          hit;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;
  logic [31:0]      value_q, value_d;

  assign pressed = ~rows_s2_q;

  always_comb begin
    tick      = kp.in_en && (div_q == DIV_W'(DWELL - 1));
    scan_done = tick && (col_q == 2'd3);
    div_d     = tick ? '0 : (kp.in_en ? div_q + 1'b1 : div_q);
    col_d     = tick ? col_q + 2'd1 : col_q;
    cols_d    = tick ? ~(4'b0001 << col_d) : cols_q;
    snap_d    = snap_q;
    if (tick) snap_d[{col_q, 2'b00} +: 4] = pressed;
  end

  // snap_d already carries column 3 in the scan-done cycle.
  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .scan_done_i (scan_done),
    .snap_i      (snap_d),
    .stable_o    (stable),
    .commit_o    (commit)
  );

  always_comb begin
    hit     = onehot_index(snap_d);
    valid_d = commit && (stable == '0) && hit.onehot;
    code_d  = valid_d ? key_code(hit.index) : code_q;
    value_d = value_q;
    if (valid_d)     value_d = {value_q[27:0], code_d};
    if (kp.in_clear) value_d = '0;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rows_s1_q <= 4'hF;
      rows_s2_q <= 4'hF;
      div_q     <= '0;
      col_q     <= '0;
      cols_q    <= 4'b1110;
      snap_q    <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      value_q   <= '0;
    end else begin
      rows_s1_q <= kp.in_rows;
      rows_s2_q <= rows_s1_q;
      div_q     <= div_d;
      col_q     <= col_d;
      cols_q    <= cols_d;
      snap_q    <= snap_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      value_q   <= value_d;
    end
  end

  assign kp.out_cols        = cols_q;
  assign kp.out_key_valid   = valid_q;
  assign kp.out_key_code    = code_q;
  assign kp.out_key_pressed = |stable;
  assign kp.out_value       = value_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keypad_scanner_if ifc ();

  keypad_scanner #(
    .SYSTEM_CLOCK_MHz (1),
    .SCAN_RATE_HZ     (250000),
    .DEBOUNCE_SCANS   (4)
  ) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .kp       (ifc)
  );

  // Keypad matrix: bit col*4+row closed pulls that row low while its column is driven.
  logic [15:0] keys = '0;
  logic [3:0]  rows;
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!ifc.out_cols[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4 + r]) rows[r] = 1'b0;
  end
  assign ifc.in_rows = rows;

  int          checks = 0;
  int          errors = 0;
  int          ev_count = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  logic [31:0] exp_value = '0;
  logic        clr_at_edge = 1'b0;

  always @(posedge clk) clr_at_edge <= ifc.in_clear;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_value = '0;
    end else if (ifc.out_key_valid) begin
      ev_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: code=%h, none expected", ifc.out_key_code);
      end else begin
        exp_code = exp_q.pop_front();
        if (ifc.out_key_code !== exp_code) begin
          errors++;
          $display("FAIL event_code: got %h, want %h", ifc.out_key_code, exp_code);
        end
        exp_value = clr_at_edge ? 32'h0 : {exp_value[27:0], exp_code};
        checks++;
        if (ifc.out_value !== exp_value) begin
          errors++;
          $display("FAIL event_value: got %h, want %h", ifc.out_value, exp_value);
        end
      end
    end else if (clr_at_edge) begin
      exp_value = '0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_events: pending=%0d, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic press_release(input int row, input int col, input logic [3:0] code);
    exp_q.push_back(code);
    keys = 16'(1) << (col*4 + row);
    wait_cycles(160);
    keys = '0;
    wait_cycles(96);
  endtask

  task automatic test_reset;
    logic [3:0] want;
    rst_n = 1'b0; ifc.in_en = 1'b0; ifc.in_clear = 1'b0;
    wait_cycles(3);
    checks += 5;
    if (ifc.out_cols !== 4'b1110) begin errors++; $display("FAIL reset_cols: got %b, want 1110", ifc.out_cols); end
    if (ifc.out_key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, want 0", ifc.out_key_valid); end
    if (ifc.out_key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h, want 0", ifc.out_key_code); end
    if (ifc.out_key_pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed: got %b, want 0", ifc.out_key_pressed); end
    if (ifc.out_value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h, want 0", ifc.out_value); end
    rst_n = 1'b1; ifc.in_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      wait_cycles(1);
      want = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (ifc.out_cols !== want) begin
        errors++;
        $display("FAIL scan_cols[%0d]: got %b, want %b", k, ifc.out_cols, want);
      end
    end
    wait_cycles(96);
  endtask

  task automatic test_single_press;
    int ev0;
    ev0 = ev_count;
    exp_q.push_back(4'h6);
    keys = 16'(1) << (2*4 + 1);
    wait_cycles(160);
    check_drained("single");
    checks += 4;
    if (ev_count - ev0 != 1) begin errors++; $display("FAIL single_events: got %0d, want 1", ev_count - ev0); end
    if (ifc.out_key_code !== 4'h6) begin errors++; $display("FAIL single_code: got %h, want 6", ifc.out_key_code); end
    if (ifc.out_value !== 32'h6) begin errors++; $display("FAIL single_value: got %h, want 6", ifc.out_value); end
    if (ifc.out_key_pressed !== 1'b1) begin errors++; $display("FAIL single_pressed: got %b, want 1", ifc.out_key_pressed); end
    keys = '0;
    wait_cycles(96);
    checks += 2;
    if (ifc.out_key_pressed !== 1'b0) begin errors++; $display("FAIL release_pressed: got %b, want 0", ifc.out_key_pressed); end
    if (ev_count - ev0 != 1) begin errors++; $display("FAIL release_events: got %0d, want 1", ev_count - ev0); end
  endtask

  task automatic test_sequence;
    int ev0;
    ifc.in_clear = 1'b1;
    wait_cycles(1);
    ifc.in_clear = 1'b0;
    ev0 = ev_count;
    press_release(0, 0, 4'h1);
    press_release(0, 3, 4'hA);
    press_release(3, 3, 4'hD);
    press_release(3, 0, 4'h0);
    check_drained("sequence");
    checks += 2;
    if (ifc.out_value !== 32'h1AD0) begin errors++; $display("FAIL sequence_value: got %h, want 00001ad0", ifc.out_value); end
    if (ev_count - ev0 != 4) begin errors++; $display("FAIL sequence_events: got %0d, want 4", ev_count - ev0); end
  endtask

  task automatic test_bounce;
    int ev0;
    ev0 = ev_count;
    exp_q.push_back(4'hF);
    for (int i = 0; i < 12; i++) begin
      keys = (i % 2 == 0) ? (16'(1) << (1*4 + 3)) : 16'h0;
      wait_cycles(8);
    end
    keys = 16'(1) << (1*4 + 3);
    wait_cycles(160);
    check_drained("bounce");
    checks += 2;
    if (ev_count - ev0 != 1) begin errors++; $display("FAIL bounce_events: got %0d, want 1", ev_count - ev0); end
    if (ifc.out_key_code !== 4'hF) begin errors++; $display("FAIL bounce_code: got %h, want f", ifc.out_key_code); end
    keys = '0;
    wait_cycles(96);
  endtask

  task automatic test_multi_key;
    int ev0;
    ev0 = ev_count;
    keys = (16'(1) << (1*4 + 1)) | (16'(1) << (2*4 + 2));
    wait_cycles(160);
    checks += 2;
    if (ev_count != ev0) begin errors++; $display("FAIL multi_events: got %0d, want 0", ev_count - ev0); end
    if (ifc.out_key_pressed !== 1'b1) begin errors++; $display("FAIL multi_pressed: got %b, want 1", ifc.out_key_pressed); end
    keys = 16'(1) << (1*4 + 1);
    wait_cycles(160);
    checks++;
    if (ev_count != ev0) begin errors++; $display("FAIL multi_partial_events: got %0d, want 0", ev_count - ev0); end
    keys = '0;
    wait_cycles(96);
    press_release(1, 1, 4'h5);
    check_drained("multi");
    checks++;
    if (ev_count - ev0 != 1) begin errors++; $display("FAIL multi_final_events: got %0d, want 1", ev_count - ev0); end
  endtask

  task automatic test_clear_disable_reset;
    int         ev0;
    logic [3:0] held;
    ifc.in_clear = 1'b1;
    press_release(0, 2, 4'h3);
    ifc.in_clear = 1'b0;
    check_drained("clear");
    checks += 2;
    if (ifc.out_value !== 32'h0) begin errors++; $display("FAIL clear_value: got %h, want 0", ifc.out_value); end
    if (ifc.out_key_code !== 4'h3) begin errors++; $display("FAIL clear_code: got %h, want 3", ifc.out_key_code); end

    ev0 = ev_count;
    ifc.in_en = 1'b0;
    held = ifc.out_cols;
    keys = 16'(1) << (1*4 + 0);
    for (int i = 0; i < 100; i++) begin
      wait_cycles(1);
      checks++;
      if (ifc.out_cols !== held) begin
        errors++;
        $display("FAIL disable_cols[%0d]: got %b, want %b", i, ifc.out_cols, held);
      end
    end
    keys = '0;
    ifc.in_en = 1'b1;
    wait_cycles(96);
    checks++;
    if (ev_count != ev0) begin errors++; $display("FAIL disable_events: got %0d, want 0", ev_count - ev0); end

    keys = 16'(1) << (0*4 + 2);
    wait_cycles(40);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (ifc.out_cols !== 4'b1110) begin errors++; $display("FAIL midreset_cols: got %b, want 1110", ifc.out_cols); end
    if (ifc.out_key_pressed !== 1'b0) begin errors++; $display("FAIL midreset_pressed: got %b, want 0", ifc.out_key_pressed); end
    keys = '0;
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(160);
    checks++;
    if (ev_count != ev0) begin errors++; $display("FAIL midreset_events: got %0d, want 0", ev_count - ev0); end
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.in_en = 1'b0;
    ifc.in_clear = 1'b0;
    test_reset();
    test_single_press();
    test_sequence();
    test_bounce();
    test_multi_key();
    test_clear_disable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix hex keypad by driving one column low at a time and sampling the four row lines. Each full scan is debounced over several consecutive identical snapshots. Every clean single-key press produces a one-cycle event with its hex code and shifts that code into a 32-bit digit register. It is the input counterpart of the seven-segment display path: `out_value` feeds the display controller's `in_value` directly, so typed digits scroll in from the right.

## Interface
Parameters:
- `SYSTEM_CLOCK_MHz`, 100: clock frequency; used only for the dwell divider.
- `SCAN_RATE_HZ`, 1000: column switch rate, giving `DWELL = SYSTEM_CLOCK_MHz*1000000/SCAN_RATE_HZ` cycles per column. `DWELL` must be ≥ 4.
- `DEBOUNCE_SCANS`, 4: number of consecutive identical full-scan snapshots required to commit a new key state. Must be ≥ 2.

Ports:
- `in_clk` in 1: system clock, all logic on the rising edge.
- `in_rst_n` in 1: one clock; reset is asynchronous and active-low.
- `in_en` in 1: scan enable; low freezes the divider, column and debounce state.
- `in_clear` in 1: synchronous clear of `out_value`.
- `in_rows` in 4: keypad rows, active-low, externally pulled up, asynchronous.
- `out_cols` out 4: keypad columns, active-low, exactly one bit low at any time.
- `out_key_valid` out 1: one-cycle press event.
- `out_key_code` out 4: hex code of the last event, held until the next event.
- `out_key_pressed` out 1: committed state has at least one key down.
- `out_value` out 32: last 8 codes, newest in `[3:0]`.

## Operation
- `in_rows` passes through a 2-flop synchronizer, then is inverted so that 1 = pressed.
- Divider: counts `0..DWELL-1` while `in_en` is high. The tick is asserted in the cycle the count equals `DWELL-1`.
- On a tick:
  - The 4 synchronized row bits are written into `snap[col*4 +: 4]`.
  - `col` advances, wrapping 3→0.
  - `out_cols <= ~(4'b0001 << next col)`.
- When the tick that samples col 3 occurs, the scan is complete:
  - If the new snapshot equals the previous snapshot, `match_cnt` increments, saturating at `DEBOUNCE_SCANS-1`. Otherwise `match_cnt` returns to 0.
  - The snapshot is committed to `stable` when `DEBOUNCE_SCANS` consecutive snapshots are identical, i.e. on the scan where `match_cnt` reaches `DEBOUNCE_SCANS-1`.
- Event generation on commit:
  - If the old `stable` is zero and the new `stable` has exactly one bit set, `out_key_valid` pulses for 1 cycle. `out_key_code` is set to `KEY_MAP[index]`, where index = `row*4 + col`.
  - Any other transition (release, multi-key, one-key→other-key without release) produces no event.
- `out_key_pressed` = |`stable`.
- `out_value`:
  - In the event cycle, `out_value <= {out_value[27:0], code}`.
  - `in_clear` forces zero and wins over a simultaneous event; the event's `out_key_valid`/`out_key_code` still occur.
- Reset values:
  - `out_cols` = 4'b1110; `out_key_valid`, `out_key_code`, `out_key_pressed` and `out_value` = 0.
  - `col`, the divider, `snap`, `stable` and `match_cnt` = 0.
- Asserting `in_rst_n` low mid-scan clears all state immediately. No event is emitted on release of reset.
- `in_en` low:
  - No ticks, no events; `out_cols` holds.
  - `in_clear` still acts.
  - On re-enable, scanning resumes from the held state.

## Timing
- Row sampling occurs `DWELL` cycles after a column is driven, giving ample settling; the synchronizer adds 2 cycles.
- One scan = `4*DWELL` cycles.
- From a stable press to `out_key_valid`: at most `(DEBOUNCE_SCANS+1)*4*DWELL + 3` cycles; at least `(DEBOUNCE_SCANS-1)*4*DWELL`.
- `out_key_valid` and the `out_value` update share the same cycle. `out_key_code` is valid in that cycle and held afterwards.
- Bounces shorter than one scan never commit.

## Structure
- Package `keypad_pkg`:
  - `KEY_MAP` constant, 16×4 bits. Row 0: 1 2 3 A; row 1: 4 5 6 B; row 2: 7 8 9 C; row 3: 0 F E D (col 0..3 left to right).
  - Function `onehot_index(16-bit)` returning the index plus an is-onehot flag.
- One sub-module: `keypad_debounce`. It takes the snapshot and scan-done strobe, and outputs `stable` plus the commit strobe.
- The divider and column logic stay in the top.

## Test plan
All scenarios use `SYSTEM_CLOCK_MHz=1`, `SCAN_RATE_HZ=250000` (`DWELL`=4) and `DEBOUNCE_SCANS=4`.
- **Reset:** `in_rst_n` low → `out_cols`=4'b1110, all outputs 0. Release, `in_en`=1 → `out_cols` sequence 1110, 1101, 1011, 0111, with a change every 4 cycles.
- **Single press:** row 1 low only while col 2 is driven, held 10 scans → exactly one `out_key_valid`, code 4'h6, `out_value`=32'h6, `out_key_pressed`=1. Release → `out_key_pressed` falls, no event.
- **Sequence:** press/release keys '1', 'A', 'D', '0' → `out_value`=32'h1AD0, with 4 valid pulses.
- **Bounce:** row toggles every 8 cycles for 6 scans, then holds low for key 'F' → a single event with code 4'hF.
- **Multi-key:** '5' and '9' pressed together → no event. Release '9' while holding '5' → no event. Full release then '5' → event with code 5.
- **Clear, disable and reset:**
  - `in_clear` in the same cycle as an event → `out_value`=0, `out_key_code` updated.
  - `in_en`=0 for 100 cycles → `out_cols` constant, no events.
  - `in_rst_n` low mid-debounce → no event after release.
